// File: rtl/net_msg_queue.sv
// Receive-side message queue: circular FIFO of network procedure-call messages feeding the messenger.
// Compile with MSGQ_DROPCNT_EN defined to add the saturating DROPCNT port and counter.
module net_msg_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MSGSTB,
  input  logic [121:0]  MSGDATA,
  output logic          INRDY,
  output logic          NETREQ,
  output logic [121:0]  NETPARAM,
  input  logic          NETMSGRD,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  output logic          UNDF,
  input  logic          FLAGCLR
`ifdef MSGQ_DROPCNT_EN
  ,
  output logic [15:0]   DROPCNT
`endif
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [121:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp, rp_next;
  logic [AW:0]   cnt, cnt_next;
  logic          push_acc, pop_acc, drop, under;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
  always_comb begin
    pop_acc  = NETMSGRD && (cnt != '0);
    push_acc = MSGSTB && ((cnt != FULL) || pop_acc);
    drop     = MSGSTB && !push_acc;
    under    = NETMSGRD && (cnt == '0);
    rp_next  = rp + AW'(pop_acc);
    cnt_next = cnt + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
  end

  always_ff @(posedge CLK) begin
    if (push_acc && !RESET) mem[wp] <= MSGDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      INRDY    <= 1'b1;
      NETREQ   <= 1'b0;
      NETPARAM <= '0;
    end else begin
      wp     <= wp + AW'(push_acc);
      rp     <= rp_next;
      cnt    <= cnt_next;
      INRDY  <= (cnt_next != FULL);
      NETREQ <= (cnt_next != '0);
      // When the new head is the entry being written this cycle, the array is not yet updated.
      if (cnt_next != '0)
        NETPARAM <= (push_acc && (wp == rp_next)) ? MSGDATA : mem[rp_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLAGCLR) begin
      OVF  <= 1'b0;
      UNDF <= 1'b0;
    end else begin
      if (drop)  OVF  <= 1'b1;
      if (under) UNDF <= 1'b1;
    end
  end

`ifdef MSGQ_DROPCNT_EN
  always_ff @(posedge CLK) begin
    if (RESET || FLAGCLR)                   DROPCNT <= '0;
    else if (drop && (DROPCNT != 16'hFFFF)) DROPCNT <= DROPCNT + 16'd1;
  end
`endif

  assign COUNT = cnt;

endmodule

// File: tb/tb_net_msg_queue.sv
// Directed bench for net_msg_queue (DEPTH=8) with hand-computed expectations.
module tb_net_msg_queue;

  logic         CLK = 1'b0;
  logic         RESET, MSGSTB, NETMSGRD, FLAGCLR;
  logic [121:0] MSGDATA;
  logic         INRDY, NETREQ, OVF, UNDF;
  logic [121:0] NETPARAM;
  logic [3:0]   COUNT;
`ifdef MSGQ_DROPCNT_EN
  logic [15:0]  DROPCNT;
`endif

  int checks = 0;
  int errors = 0;

  net_msg_queue #(.DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .MSGSTB(MSGSTB), .MSGDATA(MSGDATA),
    .INRDY(INRDY), .NETREQ(NETREQ), .NETPARAM(NETPARAM), .NETMSGRD(NETMSGRD),
    .COUNT(COUNT), .OVF(OVF), .UNDF(UNDF), .FLAGCLR(FLAGCLR)
`ifdef MSGQ_DROPCNT_EN
    , .DROPCNT(DROPCNT)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [121:0] mk(input logic [31:0] p);
    return {2'd2, 24'h00A5A5, p[15:0], ~p[15:0], p, ~p};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock, then sample #1 after the edge with strobes dropped.
  task automatic cyc(input logic stb, input logic [31:0] p, input logic rd, input logic clr);
    MSGSTB = stb; MSGDATA = mk(p); NETMSGRD = rd; FLAGCLR = clr;
    @(posedge CLK); #1;
    MSGSTB = 0; NETMSGRD = 0; FLAGCLR = 0; RESET = 0;
  endtask

  task automatic chk_drop(input string tag, input logic [15:0] exp);
`ifdef MSGQ_DROPCNT_EN
    chk(tag, 128'(DROPCNT), 128'(exp));
`else
    if (exp == 16'hFFFF) $display("unreachable %s", tag);
`endif
  endtask

  initial begin
    RESET = 1; MSGSTB = 0; NETMSGRD = 0; FLAGCLR = 0; MSGDATA = '0;
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 0;
    chk("rst_inrdy", 128'(INRDY), 128'(1));
    chk("rst_netreq", 128'(NETREQ), 128'(0));
    chk("rst_param", 128'(NETPARAM), 128'(0));
    chk("rst_count", 128'(COUNT), 128'(0));
    chk("rst_ovf", 128'(OVF), 128'(0));
    chk("rst_undf", 128'(UNDF), 128'(0));
    chk_drop("rst_drop", 16'd0);

    // single push / pop
    cyc(1, 32'h11111111, 0, 0);
    chk("a_netreq", 128'(NETREQ), 128'(1));
    chk("a_param", 128'(NETPARAM), 128'(mk(32'h11111111)));
    chk("a_count", 128'(COUNT), 128'(1));
    cyc(0, 0, 1, 0);
    chk("a_pop_netreq", 128'(NETREQ), 128'(0));
    chk("a_pop_count", 128'(COUNT), 128'(0));
    chk("a_pop_undf", 128'(UNDF), 128'(0));

    // fill, overflow
    for (int i = 0; i < 8; i++) cyc(1, 100 + i, 0, 0);
    chk("full_inrdy", 128'(INRDY), 128'(0));
    chk("full_count", 128'(COUNT), 128'(8));
    cyc(1, 999, 0, 0);
    chk("ovf_set", 128'(OVF), 128'(1));
    chk("ovf_count", 128'(COUNT), 128'(8));
    chk("ovf_head", 128'(NETPARAM), 128'(mk(100)));
    chk_drop("ovf_drop", 16'd1);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", 128'(OVF), 128'(0));
    chk_drop("clr_drop", 16'd0);

    // push+pop while full
    cyc(1, 200, 1, 0);
    chk("pp_full_count", 128'(COUNT), 128'(8));
    chk("pp_full_ovf", 128'(OVF), 128'(0));
    chk("pp_full_inrdy", 128'(INRDY), 128'(0));
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", 128'(NETPARAM), 128'(mk(i < 7 ? 101 + i : 200)));
      cyc(0, 0, 1, 0);
    end
    chk("drain_netreq", 128'(NETREQ), 128'(0));
    chk("drain_count", 128'(COUNT), 128'(0));
    chk("drain_undf", 128'(UNDF), 128'(0));

    // underflow, push+pop on empty, flag clear priority
    cyc(0, 0, 1, 0);
    chk("undf_set", 128'(UNDF), 128'(1));
    chk("undf_count", 128'(COUNT), 128'(0));
    cyc(1, 300, 1, 0);
    chk("pp_empty_count", 128'(COUNT), 128'(1));
    chk("pp_empty_head", 128'(NETPARAM), 128'(mk(300)));
    cyc(0, 0, 1, 0);
    chk("pp_empty_pop", 128'(COUNT), 128'(0));
    cyc(0, 0, 1, 1);
    chk("clr_prio_undf", 128'(UNDF), 128'(0));
    chk("clr_prio_ovf", 128'(OVF), 128'(0));
    chk_drop("clr_prio_drop", 16'd0);

    // pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1, i, 0, 0);
      chk("wrap_count", 128'(COUNT), 128'(1));
      chk("wrap_head", 128'(NETPARAM), 128'(mk(i)));
      cyc(0, 0, 1, 0);
      chk("wrap_empty", 128'(COUNT), 128'(0));
    end

    // push+pop at occupancy 1: new entry becomes head immediately
    cyc(1, 50, 0, 0);
    cyc(1, 51, 1, 0);
    chk("pp_one_count", 128'(COUNT), 128'(1));
    chk("pp_one_head", 128'(NETPARAM), 128'(mk(51)));
    cyc(0, 0, 1, 0);

    // reset mid-operation
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 400 + i, 0, 0);
    chk("pre_rst_count", 128'(COUNT), 128'(5));
    chk("pre_rst_undf", 128'(UNDF), 128'(1));
    RESET = 1;
    cyc(1, 500, 1, 0);
    chk("mid_rst_count", 128'(COUNT), 128'(0));
    chk("mid_rst_netreq", 128'(NETREQ), 128'(0));
    chk("mid_rst_inrdy", 128'(INRDY), 128'(1));
    chk("mid_rst_undf", 128'(UNDF), 128'(0));
    chk("mid_rst_ovf", 128'(OVF), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
